decode3_split_ctrl: RTL and testbench

//  Sequencer for the Decode3 stage. It splits one decoded instruction into 1..MAX_UOPS uops
//  (fused FP ops, multi-uop forms) and emits them to rename in order. While uops remain, it

---
 rtl/decode3_split_if.sv | 26 ++
 rtl/decode3_split_ctrl.sv | 148 ++++++++++++++
 tb/tb_decode3_split_ctrl.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/decode3_split_if.sv
// Decode3 split sequencer bus: instruction/flush/back-pressure in, uop sequencing out.
// master is the Decode3 side that drives the instruction; slave is the split controller.
interface decode3_split_if #(
  parameter int CNT_W = 3
);
  logic             flush_valid;
  logic             in_valid;
  logic [CNT_W-1:0] in_uop_cnt;
  logic             rn_stall;
  logic             stall_up;
  logic             uop_valid;
  logic [CNT_W-1:0] uop_idx;
  logic             uop_first;
  logic             uop_last;
  logic             busy;

  modport master (
    output flush_valid, in_valid, in_uop_cnt, rn_stall,
    input  stall_up, uop_valid, uop_idx, uop_first, uop_last, busy
  );

  modport slave (
    input  flush_valid, in_valid, in_uop_cnt, rn_stall,
    output stall_up, uop_valid, uop_idx, uop_first, uop_last, busy
  );
endinterface

// File: rtl/decode3_split_ctrl.sv
// Decode3 uop split sequencer: walks one instruction through 1..MAX_UOPS uops, holding
// ID2/ID3 via stall_up until the last uop is accepted by rename.
module decode3_split_ctrl #(
  parameter int MAX_UOPS = 4,
  parameter int CNT_W    = 3,
  parameter int PERF_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clk_en,
  decode3_split_if.slave    bus,
  output logic [PERF_W-1:0] perf_split,
  output logic [PERF_W-1:0] perf_hold
);

  localparam logic [0:0]        IDLE   = 1'b0;
  localparam logic [0:0]        SPLIT  = 1'b1;
  localparam logic [CNT_W-1:0]  ZERO_C = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  ONE_C  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  MAX_C  = CNT_W'(MAX_UOPS);
  localparam logic [PERF_W-1:0] PZERO_C = {PERF_W{1'b0}};
  localparam logic [PERF_W-1:0] PONE_C  = {{(PERF_W-1){1'b0}}, 1'b1};

  // 0 and 1 both mean a single uop; over-range counts clamp to MAX_UOPS
  function automatic logic [CNT_W-1:0] eff_count(input logic [CNT_W-1:0] cnt);
    logic [CNT_W-1:0] res;
    if (cnt == ZERO_C) begin
      res = ONE_C;
    end else if (cnt > MAX_C) begin
      res = MAX_C;
    end else begin
      res = cnt;
    end
    return res;
  endfunction

  logic [0:0]        state_r;
  logic [0:0]        state_nxt_s;
  logic [CNT_W-1:0]  idx_r;
  logic [CNT_W-1:0]  idx_nxt_s;
  logic [PERF_W-1:0] perf_split_r;
  logic [PERF_W-1:0] perf_hold_r;

  logic [CNT_W-1:0]  eff_cnt_s;
  logic [CNT_W-1:0]  last_idx_s;
  logic [CNT_W-1:0]  uop_idx_s;
  logic              multi_s;
  logic              uop_valid_s;
  logic              uop_last_s;
  logic              final_s;
  logic              split_hold_s;
  logic              advance_s;
  logic              split_inc_s;
  logic              hold_inc_s;

  // Zero-latency uop decode from the current state and the presented instruction
  always_comb begin
    eff_cnt_s    = eff_count(bus.in_uop_cnt);
    last_idx_s   = eff_cnt_s - ONE_C;
    multi_s      = (eff_cnt_s > ONE_C);
    uop_valid_s  = bus.in_valid & ~bus.flush_valid;
    uop_idx_s    = (state_r == SPLIT) ? idx_r : ZERO_C;
    uop_last_s   = (uop_idx_s == last_idx_s);
    // Terminates the split even if the count shrank under a busy instruction
    final_s      = (uop_idx_s >= last_idx_s);
    split_hold_s = uop_valid_s & multi_s & ~uop_last_s;
    advance_s    = uop_valid_s & ~bus.rn_stall & clk_en;
    split_inc_s  = advance_s & multi_s & uop_last_s;
    hold_inc_s   = split_hold_s & ~bus.rn_stall;
  end

  assign bus.uop_valid = uop_valid_s;
  assign bus.uop_idx   = uop_idx_s;
  assign bus.uop_first = (uop_idx_s == ZERO_C);
  assign bus.uop_last  = uop_last_s;
  assign bus.stall_up  = bus.rn_stall | split_hold_s;
  assign bus.busy      = (state_r == SPLIT);
  assign perf_split    = perf_split_r;
  assign perf_hold     = perf_hold_r;

  // Sequencer next state; flush outranks any advance
  always_comb begin
    state_nxt_s = state_r;
    idx_nxt_s   = idx_r;
    if (bus.flush_valid) begin
      state_nxt_s = IDLE;
      idx_nxt_s   = ZERO_C;
    end else begin
      case (state_r)
        IDLE: begin
          if (advance_s && multi_s) begin
            state_nxt_s = SPLIT;
            idx_nxt_s   = ONE_C;
          end else begin
            state_nxt_s = IDLE;
            idx_nxt_s   = ZERO_C;
          end
        end
        SPLIT: begin
          if (!bus.in_valid) begin
            state_nxt_s = IDLE;
            idx_nxt_s   = ZERO_C;
          end else if (advance_s && final_s) begin
            state_nxt_s = IDLE;
            idx_nxt_s   = ZERO_C;
          end else if (advance_s) begin
            state_nxt_s = SPLIT;
            idx_nxt_s   = idx_r + ONE_C;
          end else begin
            state_nxt_s = SPLIT;
            idx_nxt_s   = idx_r;
          end
        end
        default: begin
          state_nxt_s = IDLE;
          idx_nxt_s   = ZERO_C;
        end
      endcase
    end
  end

  // Sequencer state register, frozen while clk_en is low
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      idx_r   <= ZERO_C;
    end else if (clk_en) begin
      state_r <= state_nxt_s;
      idx_r   <= idx_nxt_s;
    end
  end

  // Performance counters, wrapping at their natural width
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_split_r <= PZERO_C;
      perf_hold_r  <= PZERO_C;
    end else if (clk_en) begin
      if (split_inc_s) begin
        perf_split_r <= perf_split_r + PONE_C;
      end
      if (hold_inc_s) begin
        perf_hold_r <= perf_hold_r + PONE_C;
      end
    end
  end

endmodule

// File: tb/tb_decode3_split_ctrl.sv
// Self-checking bench for decode3_split_ctrl: directed vector table, a hand-written
// clock-enable/reset sequence, then randomized traffic against a uop-position model.
module tb_decode3_split_ctrl;

  logic        clk;
  logic        rst;
  logic        clk_en;
  logic [31:0] perf_split;
  logic [31:0] perf_hold;
  int          total;
  int          bad;

  decode3_split_if #(.CNT_W(3)) bus ();

  decode3_split_ctrl #(.MAX_UOPS(4), .CNT_W(3), .PERF_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .clk_en     (clk_en),
    .bus        (bus),
    .perf_split (perf_split),
    .perf_hold  (perf_hold)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [2:0] cnt;
    logic       rn;
    logic       fl;
    logic [2:0] e_idx;
    logic       e_stall;
    logic       e_valid;
    logic       e_first;
    logic       e_last;
    logic       e_busy;
    int         e_ps;
    int         e_ph;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic v, input logic [2:0] cnt, input logic rn,
                              input logic fl, input logic [2:0] idx, input logic stall,
                              input logic valid, input logic first, input logic last,
                              input logic busy, input int ps, input int ph);
    vec_t t;
    t.v = v; t.cnt = cnt; t.rn = rn; t.fl = fl;
    t.e_idx = idx; t.e_stall = stall; t.e_valid = valid; t.e_first = first;
    t.e_last = last; t.e_busy = busy; t.e_ps = ps; t.e_ph = ph;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [2:0] cnt, input logic rn,
                       input logic fl, input logic en, input logic r);
    bus.in_valid    = v;
    bus.in_uop_cnt  = cnt;
    bus.rn_stall    = rn;
    bus.flush_valid = fl;
    clk_en          = en;
    rst             = r;
  endtask

  // uop-position model: pos = uops of the current instruction already accepted
  int m_pos, m_ps, m_ph, eff;
  logic [2:0] hold_cnt;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    total = 0;
    bad   = 0;
    drive(1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    repeat (2) @(negedge clk);

    tbl.push_back(mk(1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0, 0));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(1'b1, 3'd1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 0, 0));
    tbl.push_back(mk(1'b1, 3'd3, 1'b0, 1'b0, 3'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0));
    tbl.push_back(mk(1'b1, 3'd3, 1'b0, 1'b0, 3'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 0, 1));
    tbl.push_back(mk(1'b1, 3'd3, 1'b0, 1'b0, 3'd2, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 0, 2));
    tbl.push_back(mk(1'b1, 3'd4, 1'b0, 1'b0, 3'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1, 2));
    tbl.push_back(mk(1'b1, 3'd4, 1'b0, 1'b0, 3'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1, 3));
    tbl.push_back(mk(1'b1, 3'd4, 1'b1, 1'b0, 3'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1, 4));
    tbl.push_back(mk(1'b1, 3'd4, 1'b0, 1'b0, 3'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1, 4));
    tbl.push_back(mk(1'b1, 3'd4, 1'b0, 1'b0, 3'd3, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1, 5));
    tbl.push_back(mk(1'b1, 3'd4, 1'b0, 1'b0, 3'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2, 5));
    tbl.push_back(mk(1'b1, 3'd4, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2, 6));
    tbl.push_back(mk(1'b1, 3'd1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2, 6));
    tbl.push_back(mk(1'b1, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2, 6));
    tbl.push_back(mk(1'b1, 3'd7, 1'b0, 1'b0, 3'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2, 6));
    tbl.push_back(mk(1'b1, 3'd7, 1'b0, 1'b0, 3'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2, 7));
    tbl.push_back(mk(1'b1, 3'd7, 1'b0, 1'b0, 3'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2, 8));
    tbl.push_back(mk(1'b1, 3'd7, 1'b0, 1'b0, 3'd3, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2, 9));
    tbl.push_back(mk(1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3, 9));

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].v, tbl[i].cnt, tbl[i].rn, tbl[i].fl, 1'b1, 1'b0);
      #1;
      chk($sformatf("vec%0d.idx", i),   32'(bus.uop_idx),   32'(tbl[i].e_idx));
      chk($sformatf("vec%0d.stall", i), 32'(bus.stall_up),  32'(tbl[i].e_stall));
      chk($sformatf("vec%0d.valid", i), 32'(bus.uop_valid), 32'(tbl[i].e_valid));
      chk($sformatf("vec%0d.first", i), 32'(bus.uop_first), 32'(tbl[i].e_first));
      chk($sformatf("vec%0d.last", i),  32'(bus.uop_last),  32'(tbl[i].e_last));
      chk($sformatf("vec%0d.busy", i),  32'(bus.busy),      32'(tbl[i].e_busy));
      chk($sformatf("vec%0d.psplit", i), perf_split, 32'(tbl[i].e_ps));
      chk($sformatf("vec%0d.phold", i),  perf_hold,  32'(tbl[i].e_ph));
      @(negedge clk);
    end

    // clock-enable freeze mid-split, then reset mid-split
    drive(1'b1, 3'd4, 1'b0, 1'b0, 1'b1, 1'b0);
    #1 chk("ce.start_idx", 32'(bus.uop_idx), 32'd0);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 3'd4, 1'b0, 1'b0, 1'b0, 1'b0);
      #1;
      chk($sformatf("ce.frz%0d.idx", i),   32'(bus.uop_idx),  32'd1);
      chk($sformatf("ce.frz%0d.busy", i),  32'(bus.busy),     32'd1);
      chk($sformatf("ce.frz%0d.stall", i), 32'(bus.stall_up), 32'd1);
      chk($sformatf("ce.frz%0d.ph", i),    perf_hold,         32'd10);
      chk($sformatf("ce.frz%0d.ps", i),    perf_split,        32'd3);
      @(negedge clk);
    end
    drive(1'b1, 3'd4, 1'b0, 1'b0, 1'b1, 1'b0);
    #1 chk("ce.resume_idx", 32'(bus.uop_idx), 32'd1);
    @(negedge clk);
    drive(1'b1, 3'd4, 1'b0, 1'b0, 1'b1, 1'b1);
    #1 chk("rst.pre_idx", 32'(bus.uop_idx), 32'd2);
    chk("rst.pre_ph", perf_hold, 32'd11);
    @(negedge clk);
    drive(1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    #1;
    chk("rst.busy",  32'(bus.busy),     32'd0);
    chk("rst.idx",   32'(bus.uop_idx),  32'd0);
    chk("rst.stall", 32'(bus.stall_up), 32'd0);
    chk("rst.ps",    perf_split,        32'd0);
    chk("rst.ph",    perf_hold,         32'd0);
    @(negedge clk);

    // randomized traffic; upstream keeps the instruction stable while it is mid-split
    m_pos = 0; m_ps = 0; m_ph = 0; hold_cnt = 3'd0;
    for (int n = 0; n < 3000; n++) begin
      logic v, rn, fl, en, r, e_valid, e_last, e_hold;
      logic [2:0] cnt;
      r  = ($urandom_range(0, 99) < 2);
      en = ($urandom_range(0, 99) < 85);
      fl = ($urandom_range(0, 99) < 6);
      rn = ($urandom_range(0, 99) < 25);
      if (m_pos != 0) begin
        cnt = hold_cnt;
        v   = ($urandom_range(0, 99) < 97);
      end else begin
        cnt = 3'($urandom_range(0, 7));
        v   = ($urandom_range(0, 99) < 80);
      end
      drive(v, cnt, rn, fl, en, r);
      #1;
      eff     = (cnt == 3'd0) ? 1 : ((int'(cnt) > 4) ? 4 : int'(cnt));
      e_valid = v & ~fl;
      e_last  = (m_pos == eff - 1);
      e_hold  = e_valid & (eff > 1) & ~e_last;
      chk("rnd.idx",   32'(bus.uop_idx),   32'(m_pos));
      chk("rnd.valid", 32'(bus.uop_valid), 32'(e_valid));
      chk("rnd.first", 32'(bus.uop_first), 32'(m_pos == 0));
      chk("rnd.last",  32'(bus.uop_last),  32'(e_last));
      chk("rnd.stall", 32'(bus.stall_up),  32'(rn | e_hold));
      chk("rnd.busy",  32'(bus.busy),      32'(m_pos != 0));
      chk("rnd.ps",    perf_split,         32'(m_ps));
      chk("rnd.ph",    perf_hold,          32'(m_ph));
      if (r) begin
        m_pos = 0; m_ps = 0; m_ph = 0;
      end else if (en) begin
        if (e_hold && !rn) m_ph++;
        if (fl || !v) begin
          m_pos = 0;
        end else if (!rn) begin
          if (m_pos + 1 >= eff) begin
            if (eff > 1) m_ps++;
            m_pos = 0;
          end else begin
            m_pos++;
          end
        end
      end
      hold_cnt = cnt;
      @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
